// File: rtl/stack_sequencer_if.sv
// Single-beat bus between the stack sequencer (master) and memory (slave).
// Signal names keep the sequencer's _o/_i view so both ends read the same.
interface stack_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             bus_cyc_o;
    logic             bus_stb_o;
    logic             bus_we_o;
    logic [WIDTH-1:0] bus_adr_o;
    logic [3:0]       bus_sel_o;
    logic [WIDTH-1:0] bus_dat_o;
    logic [WIDTH-1:0] bus_dat_i;
    logic             bus_ack_i;

    modport master (
        output bus_cyc_o, bus_stb_o, bus_we_o, bus_adr_o, bus_sel_o, bus_dat_o,
        input  bus_dat_i, bus_ack_i
    );

    modport slave (
        input  bus_cyc_o, bus_stb_o, bus_we_o, bus_adr_o, bus_sel_o, bus_dat_o,
        output bus_dat_i, bus_ack_i
    );
endinterface

// File: rtl/stack_sequencer.sv
// Load/store and push/pop sequencer: one request -> one bus beat -> one writeback cycle.
// Optional bus timeout enabled by defining STACKSEQ_TIMEOUT_EN.
module stack_sequencer #(
    parameter int                WIDTH  = 32,
    parameter int                COUNTP = 4,
    parameter logic [COUNTP-1:0] SPREG  = 4'd15
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              supervisor,
    // Request handshake: a request is accepted on any edge where req_valid && req_ready.
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [1:0]        req_size,
    input  logic [WIDTH-1:0]  req_addr,
    input  logic [WIDTH-1:0]  req_data,
    input  logic [COUNTP-1:0] req_reg,
    input  logic [WIDTH-1:0]  sp_cur,
    stack_sequencer_if.master bus,
    output logic [COUNTP-1:0] write_addr,
    output logic [WIDTH-1:0]  write_data,
    output logic [1:0]        write_en,
    output logic [WIDTH-1:0]  sp_data,
    output logic [1:0]        sp_en,
    output logic              done,
    output logic              fault,
    output logic [1:0]        state_dbg
);
    typedef enum logic [1:0] {IDLE = 2'd0, BUS = 2'd1, WB = 2'd2} state_t;

    localparam logic [1:0] OP_LOAD  = 2'd0;
    localparam logic [1:0] OP_STORE = 2'd1;
    localparam logic [1:0] OP_PUSH  = 2'd2;
    localparam logic [1:0] OP_POP   = 2'd3;
    localparam logic [1:0] SZ_BYTE  = 2'd1;
    localparam logic [1:0] SZ_HALF  = 2'd2;
    localparam logic [1:0] SZ_WORD  = 2'd3;

    state_t state_q, state_d;
    logic   fault_q, fault_d;

    logic [1:0]        op_q, size_q;
    logic [WIDTH-1:0]  adr_q, wdat_q, sp_q, rdat_q;
    logic [3:0]        sel_q;
    logic [COUNTP-1:0] reg_q;
    logic              sup_q;

    logic [1:0]       acc_size;
    logic [WIDTH-1:0] acc_addr, acc_wdat;
    logic [3:0]       acc_sel;
    logic             acc_misaligned;
    logic [7:0]       rd_byte;
    logic [15:0]      rd_half;
    logic [WIDTH-1:0] rd_val;

    // Decode of the request as presented; only meaningful while IDLE.
    always_comb begin
        acc_size = (req_op[1] || req_size == 2'd0) ? SZ_WORD : req_size;
        case (req_op)
            OP_PUSH: acc_addr = sp_cur - WIDTH'(4);
            OP_POP:  acc_addr = sp_cur;
            default: acc_addr = req_addr;
        endcase
        if (req_op[1]) begin
            acc_misaligned = (sp_cur[1:0] != 2'b00);
        end else begin
            case (acc_size)
                SZ_HALF: acc_misaligned = acc_addr[0];
                SZ_WORD: acc_misaligned = (acc_addr[1:0] != 2'b00);
                default: acc_misaligned = 1'b0;
            endcase
        end
        case (acc_size)
            SZ_BYTE: begin
                acc_sel  = 4'b1000 >> acc_addr[1:0];
                acc_wdat = {4{req_data[7:0]}};
            end
            SZ_HALF: begin
                acc_sel  = acc_addr[1] ? 4'b0011 : 4'b1100;
                acc_wdat = {2{req_data[15:0]}};
            end
            default: begin
                acc_sel  = 4'b1111;
                acc_wdat = req_data;
            end
        endcase
    end

`ifdef STACKSEQ_TIMEOUT_EN
    logic [7:0] tcnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || state_q != BUS) tcnt_q <= 8'd0;
        else                         tcnt_q <= tcnt_q + 8'd1;
    end
`endif

    always_comb begin
        state_d = state_q;
        fault_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (acc_misaligned) fault_d = 1'b1;
                    else                state_d = BUS;
                end
            end
            BUS: begin
                if (bus.bus_ack_i) begin
                    state_d = WB;
                end
`ifdef STACKSEQ_TIMEOUT_EN
                // 255th BUS cycle without ack: abandon the beat.
                else if (tcnt_q == 8'd254) begin
                    state_d = IDLE;
                    fault_d = 1'b1;
                end
`endif
            end
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            fault_q <= 1'b0;
            op_q    <= 2'd0;
            size_q  <= 2'd0;
            adr_q   <= '0;
            wdat_q  <= '0;
            sel_q   <= 4'd0;
            reg_q   <= '0;
            sp_q    <= '0;
            sup_q   <= 1'b0;
            rdat_q  <= '0;
        end else begin
            state_q <= state_d;
            fault_q <= fault_d;
            if (state_q == IDLE && req_valid) begin
                op_q   <= req_op;
                size_q <= acc_size;
                adr_q  <= acc_addr;
                wdat_q <= acc_wdat;
                sel_q  <= acc_sel;
                reg_q  <= req_reg;
                sp_q   <= sp_cur;
                sup_q  <= supervisor;
            end
            if (state_q == BUS && bus.bus_ack_i) rdat_q <= bus.bus_dat_i;
        end
    end

    // Big-endian lane select: address byte 0 lives in bits [31:24].
    always_comb begin
        case (adr_q[1:0])
            2'd0:    rd_byte = rdat_q[31:24];
            2'd1:    rd_byte = rdat_q[23:16];
            2'd2:    rd_byte = rdat_q[15:8];
            default: rd_byte = rdat_q[7:0];
        endcase
        rd_half = adr_q[1] ? rdat_q[15:0] : rdat_q[31:16];
        case (size_q)
            SZ_BYTE: rd_val = {{(WIDTH-8){1'b0}}, rd_byte};
            SZ_HALF: rd_val = {{(WIDTH-16){1'b0}}, rd_half};
            default: rd_val = rdat_q;
        endcase
    end

    always_comb begin
        bus.bus_cyc_o = (state_q == BUS);
        bus.bus_stb_o = (state_q == BUS);
        bus.bus_we_o  = (state_q == BUS) && (op_q == OP_STORE || op_q == OP_PUSH);
        bus.bus_adr_o = (state_q == BUS) ? adr_q  : '0;
        bus.bus_sel_o = (state_q == BUS) ? sel_q  : 4'd0;
        bus.bus_dat_o = (state_q == BUS) ? wdat_q : '0;
        req_ready     = (state_q == IDLE);
        done          = (state_q == WB);
        fault         = fault_q;
        state_dbg     = state_q;
        write_addr    = '0;
        write_data    = '0;
        write_en      = 2'd0;
        sp_data       = '0;
        sp_en         = 2'd0;
        if (state_q == WB) begin
            case (op_q)
                OP_LOAD: begin
                    write_en   = size_q;
                    write_addr = reg_q;
                    write_data = rd_val;
                end
                OP_PUSH: begin
                    sp_en   = 2'd3;
                    sp_data = adr_q;
                end
                OP_POP: begin
                    write_en   = 2'd3;
                    write_addr = reg_q;
                    write_data = rd_val;
                    // User-mode pop into the SP register: the loaded value must win.
                    if (!(reg_q == SPREG && !sup_q)) begin
                        sp_en   = 2'd3;
                        sp_data = sp_q + WIDTH'(4);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/stack_sequencer.md
# stack_sequencer

Load/store and push/pop sequencer for the bexkat1 core. It sits between the execute stage and the register file's dual write port. It accepts one memory request at a time and runs it as a single-beat bus cycle. It then drives the register-file write port and the stack-pointer write port, in the same cycle where the operation needs both.

## Interface
- WIDTH, 32: data/address width (the byte-lane rules below require 32)
- COUNTP, 4: register index width
- SPREG, 4'd15: stack-pointer register index
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- supervisor  in  1  sampled at request accept; selects ssp vs %15 downstream (pass-through only)
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE
- req_op  in  2  0 LOAD, 1 STORE, 2 PUSH, 3 POP
- req_size  in  2  1 byte, 2 half, 3 word, 0 = word; forced to word for PUSH/POP
- req_addr  in  WIDTH  effective address (LOAD/STORE)
- req_data  in  WIDTH  store/push data, right-justified
- req_reg  in  COUNTP  destination register (LOAD/POP)
- sp_cur  in  WIDTH  current stack pointer, sampled at accept
- bus_cyc_o, bus_stb_o, bus_we_o  out  1  bus master controls
- bus_adr_o  out  WIDTH  byte address
- bus_sel_o  out  4  byte lanes, big-endian (addr[1:0]=0 → 4'b1000 for a byte)
- bus_dat_o  out  WIDTH  lane-replicated write data
- bus_dat_i  in  WIDTH  read data
- bus_ack_i  in  1  single-beat acknowledge
- write_addr  out  COUNTP; write_data  out  WIDTH; write_en  out  2  (size code; 0 = no write)
- sp_data  out  WIDTH; sp_en  out  2  stack-pointer write
- done  out  1  one-cycle completion pulse
- fault  out  1  one-cycle misalignment/timeout pulse

## Operation
- States: IDLE, BUS, WB.
- IDLE: when req_valid is high, latch all req_* inputs, sp_cur and supervisor.
  - Misaligned request (half with addr[0]=1; word with addr[1:0]≠0; any PUSH/POP with sp_cur[1:0]≠0): pulse fault next cycle, stay in IDLE, no bus cycle.
  - Otherwise go to BUS.
- Address: LOAD/STORE use req_addr. PUSH uses sp_cur−4 (mod 2^32). POP uses sp_cur.
- BUS: cyc/stb held high until bus_ack_i. we=1 for STORE/PUSH. On ack, capture read data and go to WB.
- Read extraction: select the addressed lane(s) big-endian, then zero-extend into write_data.
- WB (one cycle): done=1, then back to IDLE.
  - LOAD: write_en=size, write_addr=req_reg.
  - STORE: no writes.
  - PUSH: sp_en=3, sp_data=sp_cur−4.
  - POP: write_en=3, write_addr=req_reg, write_data=loaded word, and sp_en=3 with sp_data=sp_cur+4 in the same cycle.
  - POP into SPREG in user mode: sp_en is suppressed, so the loaded value wins. In supervisor mode both writes occur (ssp and %15 are distinct).
- bus_sel_o, bus_dat_o and bus_adr_o are held stable throughout BUS.

## Timing
- Reset values: every output 0 except req_ready=1; state IDLE.
- Accept in cycle 0; bus_cyc_o/bus_stb_o first high in cycle 1.
- Ack in cycle N gives WB (write_en/sp_en/done) in cycle N+1 and req_ready=1 in cycle N+2.
- A zero-wait ack (ack in cycle 1) gives minimum latency of 3 cycles accept-to-accept.
- write_en, sp_en, done and fault are single-cycle pulses.
- bus_ack_i outside BUS is ignored.
- rst_i mid-BUS: cyc/stb drop at that edge; no WB, no done.

## Configuration
- STACKSEQ_TIMEOUT_EN defined: an 8-bit counter runs in BUS.
  - If 255 cycles pass without ack, drop cyc/stb, pulse fault, return to IDLE with no register writes.
  - A late ack is ignored.
- Undefined: BUS waits for ack indefinitely; fault comes only from misalignment.

## Test plan
- LOAD byte, addr 0x1002, bus_dat_i=0xAABBCCDD → bus_sel_o=4'b0010, write_en=1, write_data=0x000000CC, write_addr=req_reg.
- PUSH 0x12345678, sp_cur=0x2000 → write at 0x1FFC with sel 4'b1111; WB: sp_en=3, sp_data=0x1FFC, write_en=0.
- POP into r3, sp_cur=0x1FFC, mem=0xDEADBEEF → write_en=3, r3←0xDEADBEEF, sp_data=0x2000, same cycle.
- User-mode POP into r15 → write_en=3 to SPREG, sp_en=0.
- STORE half at 0x1001 → fault pulse, bus_cyc_o never asserted, req_ready stays 1.
- Ack withheld for 300 cycles (with STACKSEQ_TIMEOUT_EN) → fault on cycle 256 of BUS; a later ack produces no write.
